// File: rtl/tt_response_checker.sv
// tt_response_checker: compares sampled (in_vec, f_obs) pairs against the
// EXPECTED truth table. It tracks coverage, counts mismatches and reports
// pass/fail once every input combination has been seen.
// Optional feature macro: TTC_TIMEOUT_EN adds a no-progress watchdog.
// Ports: clk, rst_n (async, active-low), start, in_valid, in_vec, f_obs;
//        busy, done, pass, err_count, covered, obs_table,
//        first_fail_valid, first_fail_idx, timeout.
module tt_response_checker #(
    parameter int N_IN = 3,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'hEA,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [N_IN-1:0]        in_vec,
    input  logic                   f_obs,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic [(1<<N_IN)-1:0]   covered,
    output logic [(1<<N_IN)-1:0]   obs_table,
    output logic                   first_fail_valid,
    output logic [N_IN-1:0]        first_fail_idx,
    output logic                   timeout
);

    localparam int W = 1 << N_IN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic          accept;
    logic          mism;
    logic          new_cov;
    logic          all_cov;
    logic          to_hit;
    logic [W-1:0]  cov_nxt;
    logic [N_IN:0] err_nxt;

    // start wins over a coincident sample; that sample is dropped
    always_comb begin
        accept  = (state == RUN) && in_valid && !start;
        mism    = (f_obs != EXPECTED[in_vec]);
        cov_nxt = covered | (W'(1) << in_vec);
        new_cov = accept && !covered[in_vec];
        all_cov = &cov_nxt;
        err_nxt = err_count;
        if (accept && mism && (err_count != '1))
            err_nxt = err_count + 1'b1;
    end

`ifdef TTC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    // counter measures cycles since the last new coverage bit
    assign to_hit = (state == RUN) && !start && !new_cov &&
                    (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else if (state == RUN) begin
            if (new_cov)
                cnt <= '0;
            else if (to_hit)
                timeout <= 1'b1;
            else
                cnt <= cnt + 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            covered          <= '0;
            obs_table        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (start) begin
            state            <= RUN;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            covered          <= '0;
            obs_table        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (state == RUN) begin
            if (accept) begin
                covered           <= cov_nxt;
                obs_table[in_vec] <= f_obs;
                err_count         <= err_nxt;
                if (mism && !first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= in_vec;
                end
            end
            if (accept && all_cov) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_nxt == '0);
            end else if (to_hit) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tt_response_checker.sv
// Self-checking bench for tt_response_checker: vector tables, hand-written
// corner sequences and random stimulus against a coverage/error model.
module tb_tt_response_checker;

    localparam logic [7:0] EXP_TT = 8'hEA;
    localparam int         TO_CYC = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_vec = '0;
    logic       f_obs = 1'b0;
    logic       busy, done, pass, first_fail_valid, timeout;
    logic [3:0] err_count;
    logic [7:0] covered, obs_table;
    logic [2:0] first_fail_idx;

    tt_response_checker #(
        .N_IN(3), .EXPECTED(EXP_TT), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_vec(in_vec), .f_obs(f_obs), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .covered(covered),
        .obs_table(obs_table), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // reference model: sets of seen indices and error tally
    bit       m_run, m_done, m_to, m_ffv;
    bit [7:0] m_seen, m_obs;
    int       m_err, m_ffi, m_since;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic m_clear();
        m_seen = '0; m_obs = '0; m_err = 0;
        m_ffv = 0; m_ffi = 0; m_to = 0; m_since = 0;
    endtask

    task automatic m_reset();
        m_clear();
        m_run = 0; m_done = 0;
    endtask

    task automatic m_edge(input bit st, input bit v,
                          input bit [2:0] vec, input bit f);
        bit is_new;
        if (st) begin
            m_clear();
            m_run = 1; m_done = 0;
        end else if (m_run) begin
            is_new = 0;
            if (v) begin
                is_new = !m_seen[vec];
                m_seen[vec] = 1'b1;
                m_obs[vec] = f;
                if (f != EXP_TT[vec]) begin
                    if (m_err < 15) m_err++;
                    if (!m_ffv) begin m_ffv = 1; m_ffi = vec; end
                end
            end
            if ($countones(m_seen) == 8) begin
                m_run = 0; m_done = 1;
            end
`ifdef TTC_TIMEOUT_EN
            else begin
                if (is_new) m_since = 0;
                else m_since++;
                if (m_since == TO_CYC) begin
                    m_run = 0; m_done = 1; m_to = 1;
                end
            end
`endif
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".busy"}, busy, m_run);
        chk({tag, ".done"}, done, m_done);
        chk({tag, ".pass"}, pass, m_done && m_err == 0 && !m_to);
        chk({tag, ".err"}, err_count, m_err);
        chk({tag, ".cov"}, covered, m_seen);
        chk({tag, ".obs"}, obs_table, m_obs);
        chk({tag, ".ffv"}, first_fail_valid, m_ffv);
        chk({tag, ".ffi"}, first_fail_idx, m_ffi);
        chk({tag, ".to"}, timeout, m_to);
    endtask

    task automatic step(input string tag, input bit st, input bit v,
                        input bit [2:0] vec, input bit f);
        start = st; in_valid = v; in_vec = vec; f_obs = f;
        @(posedge clk);
        #1;
        m_edge(st, v, vec, f);
        cmp_all(tag);
        start = 0; in_valid = 0;
    endtask

    typedef struct {
        bit       st;
        bit       v;
        bit [2:0] vec;
        bit       f;
        bit       e_done;
        bit       e_pass;
        int       e_err;
        bit [7:0] e_cov;
    } vrec_t;

    vrec_t tbl[18];

    initial begin
        bit fr;
        bit [2:0] rv;
        // full match rows 0..8, single fault at index 4 rows 9..17
        for (int s = 0; s < 2; s++) begin
            tbl[s*9] = '{1, 0, 3'd0, 0, 0, 0, 0, 8'h00};
            for (int i = 0; i < 8; i++) begin
                fr = EXP_TT[i] ^ (s == 1 && i == 4);
                tbl[s*9+1+i] = '{0, 1, 3'(i), fr, i == 7,
                                 i == 7 && s == 0,
                                 (s == 1 && i >= 4) ? 1 : 0,
                                 8'((1 << (i + 1)) - 1)};
            end
        end

        m_reset();
        #1;
        cmp_all("reset");
        #12 rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 18; r++) begin
            step($sformatf("tbl%0d", r), tbl[r].st, tbl[r].v,
                 tbl[r].vec, tbl[r].f);
            chk($sformatf("tbl%0d.done", r), done, tbl[r].e_done);
            chk($sformatf("tbl%0d.pass", r), pass, tbl[r].e_pass);
            chk($sformatf("tbl%0d.err", r), err_count, tbl[r].e_err);
            chk($sformatf("tbl%0d.cov", r), covered, tbl[r].e_cov);
            if (r == 8) chk("full.obs", obs_table, 8'hEA);
        end
        chk("fault.obs", obs_table, 8'hFA);
        chk("fault.ffi", first_fail_idx, 4);

        // repeats and gaps, in_valid toggling
        step("rg.start", 1, 0, 0, 0);
        step("rg.7a", 0, 1, 3'd7, 1);
        step("rg.gap", 0, 0, 3'd2, 1);
        step("rg.7b", 0, 1, 3'd7, 1);
        step("rg.0a", 0, 1, 3'd0, 0);
        step("rg.0b", 0, 1, 3'd0, 1);
        for (int i = 1; i < 7; i++) begin
            step("rg.gap", 0, 0, 3'(i), ~EXP_TT[i]);
            chk("rg.notdone", done, 0);
            step("rg.s", 0, 1, 3'(i), EXP_TT[i]);
        end
        chk("rg.done", done, 1);
        chk("rg.err", err_count, 1);
        chk("rg.ffi", first_fail_idx, 0);
        step("rg.ignored", 0, 1, 3'd3, 0);

        // start beats a coincident sample
        step("sp.start", 1, 1, 3'd0, 0);
        chk("sp.cov", covered, 8'h00);
        for (int i = 0; i < 3; i++)
            step("sp.s", 0, 1, 3'(i + 2), ~EXP_TT[i + 2]);
        step("sp.restart", 1, 0, 0, 0);
        chk("sp.err", err_count, 0);
        chk("sp.cov2", covered, 8'h00);

        // err_count saturation
        for (int i = 0; i < 20; i++)
            step("sat", 0, 1, 3'd0, 1);
        chk("sat.err", err_count, 15);

        // reset mid-run
        step("rm.start", 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            step("rm.s", 0, 1, 3'(i), EXP_TT[i]);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        cmp_all("rm.async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            step("rm.nostart", 0, 1, 3'(i), 1);
        chk("rm.cov", covered, 8'h00);

`ifdef TTC_TIMEOUT_EN
        step("to.start", 1, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            step("to.s", 0, 1, 3'(i), EXP_TT[i]);
        for (int i = 0; i < 15; i++)
            step("to.idle", 0, 0, 0, 0);
        chk("to.notyet", done, 0);
        step("to.fire", 0, 0, 0, 0);
        chk("to.done", done, 1);
        chk("to.to", timeout, 1);
        chk("to.pass", pass, 0);
        chk("to.cov", covered, 8'h7F);
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rv = 3'($urandom_range(0, 7));
            step("rnd", $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7, rv,
                 EXP_TT[rv] ^ ($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
